// File: rtl/mips_single_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_single_cycle_pkg
// Description : Shared definitions for the single-cycle MIPS subset CPU:
//               opcode and funct encodings, ALU control enum, default memory
//               base addresses and a sign-extension helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_single_cycle_pkg;

   localparam logic [31:0] DEF_TEXT_BASE = 32'h0000_3000;
   localparam logic [31:0] DEF_DATA_BASE = 32'h0000_0000;

   // Primary opcodes (instruction bits 31:26)
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instruction bits 5:0)
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_ctrl_e;

   function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_dmem.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem
// Description : Word-addressed data memory. Combinational read, write on the
//               rising edge. Byte-address bits [1:0] are ignored. Accesses
//               outside the array read 0 and drop writes.
// Ports       : clk     - clock
//               i_addr  - byte address
//               i_we    - write enable
//               i_wdata - write data
//               o_rdata - read data (old value during a write)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem
   import mips_single_cycle_pkg::*;
#(
   parameter int          DM_WORDS  = 1024,
   parameter logic [31:0] DATA_BASE = DEF_DATA_BASE
) (
   input  logic        clk,
   input  logic [31:0] i_addr,
   input  logic        i_we,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata
);

   localparam int c_idx_w = $clog2(DM_WORDS);

   logic [31:0] dataMem [0:DM_WORDS-1];

   logic [31:0] w_word;
   logic        w_in_range;

   assign w_word     = (i_addr - DATA_BASE) >> 2;
   assign w_in_range = (w_word < 32'(DM_WORDS));
   assign o_rdata    = w_in_range ? dataMem[w_word[c_idx_w-1:0]] : 32'd0;

   always_ff @(posedge clk) begin
      if (i_we && w_in_range) begin
         dataMem[w_word[c_idx_w-1:0]] <= i_wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mips_imem.sv
`default_nettype none
// ============================================================================
// Module      : mips_imem
// Description : Instruction memory, combinational word read. Contents are
//               loaded externally; fetches outside the array return 0 (nop).
// Ports       : i_addr  - byte address of the instruction
//               o_instr - instruction word
// Revision    : 1.0 - initial release
// ============================================================================
module mips_imem
   import mips_single_cycle_pkg::*;
#(
   parameter int          IM_WORDS  = 1024,
   parameter logic [31:0] TEXT_BASE = DEF_TEXT_BASE
) (
   input  logic [31:0] i_addr,
   output logic [31:0] o_instr
);

   localparam int c_idx_w = $clog2(IM_WORDS);

   logic [31:0] instruction_memory [0:IM_WORDS-1];

   logic [31:0] w_word;
   logic        w_in_range;

   // Addresses below TEXT_BASE wrap to huge word numbers and fall out of range.
   assign w_word     = (i_addr - TEXT_BASE) >> 2;
   assign w_in_range = (w_word < 32'(IM_WORDS));
   assign o_instr    = w_in_range ? instruction_memory[w_word[c_idx_w-1:0]] : 32'd0;

endmodule
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mips_regfile
// Description : 32 x 32-bit register file, two combinational read ports and
//               one write port on the rising clock edge. Register 0 reads as
//               zero and ignores writes. Reset clears every register.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_ra1, i_ra2       - read addresses
//               o_rd1, o_rd2       - read data (old value during a write)
//               i_we, i_wa, i_wd   - write enable, address, data
// Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  i_ra1,
   input  logic [4:0]  i_ra2,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2,
   input  logic        i_we,
   input  logic [4:0]  i_wa,
   input  logic [31:0] i_wd
);

   logic [31:0] rf [0:31];

   // Reset has priority over the write port in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf[i] <= '0;
         end
      end else if (i_we && (i_wa != 5'd0)) begin
         rf[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : rf[i_ra1];
   assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : rf[i_ra2];

endmodule
`default_nettype wire

// File: rtl/mips_single_cycle.sv
`default_nettype none
// ============================================================================
// Module      : mips_single_cycle
// Description : Single-cycle MIPS subset CPU (add, sub, and, or, slt, addi,
//               lw, sw, beq, j, jal). One instruction retires per clock; no
//               branch delay slot. Unknown opcodes/functs execute as nop.
// Ports       : clk - clock, all state updates on the rising edge
//               rst - synchronous active-high reset (PC <= TEXT_BASE,
//                     registers cleared, memory writes suppressed)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_single_cycle
   import mips_single_cycle_pkg::*;
#(
   parameter logic [31:0] TEXT_BASE = DEF_TEXT_BASE,
   parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
   parameter int          IM_WORDS  = 1024,
   parameter int          DM_WORDS  = 1024
) (
   input  logic clk,
   input  logic rst
);

   logic [31:0] PC;
   logic [31:0] pc_d;
   logic [31:0] AnInstruction;

   // Instruction fields
   logic [5:0]  w_op;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [5:0]  w_funct;
   logic [15:0] w_imm;
   logic [25:0] w_target;

   // Datapath
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;
   logic [31:0] w_sext;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_y;
   logic [31:0] w_mem_rdata;
   logic [31:0] w_wb_data;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_target;
   logic [31:0] w_j_target;

   // Control
   logic        w_reg_we;
   logic [4:0]  w_wa;
   logic        w_mem_we;
   logic        w_use_imm;
   logic        w_is_load;
   logic        w_is_link;
   alu_ctrl_e   w_alu_ctrl;

   mips_imem #(
      .IM_WORDS  (IM_WORDS),
      .TEXT_BASE (TEXT_BASE)
   ) im (
      .i_addr  (PC),
      .o_instr (AnInstruction)
   );

   assign w_op     = AnInstruction[31:26];
   assign w_rs     = AnInstruction[25:21];
   assign w_rt     = AnInstruction[20:16];
   assign w_rd     = AnInstruction[15:11];
   assign w_funct  = AnInstruction[5:0];
   assign w_imm    = AnInstruction[15:0];
   assign w_target = AnInstruction[25:0];

   assign w_sext      = sign_ext16(w_imm);
   assign w_pc_plus4  = PC + 32'd4;
   assign w_br_target = w_pc_plus4 + (w_sext << 2);
   assign w_j_target  = {w_pc_plus4[31:28], w_target, 2'b00};

   // Decoder and next-PC selection
   always_comb begin
      w_reg_we   = 1'b0;
      w_wa       = w_rt;
      w_mem_we   = 1'b0;
      w_use_imm  = 1'b0;
      w_is_load  = 1'b0;
      w_is_link  = 1'b0;
      w_alu_ctrl = ALU_ADD;
      pc_d       = w_pc_plus4;
      case (w_op)
         OP_RTYPE: begin
            w_wa     = w_rd;
            w_reg_we = 1'b1;
            case (w_funct)
               FN_ADD:  w_alu_ctrl = ALU_ADD;
               FN_SUB:  w_alu_ctrl = ALU_SUB;
               FN_AND:  w_alu_ctrl = ALU_AND;
               FN_OR:   w_alu_ctrl = ALU_OR;
               FN_SLT:  w_alu_ctrl = ALU_SLT;
               default: w_reg_we   = 1'b0;
            endcase
         end
         OP_ADDI: begin
            w_reg_we  = 1'b1;
            w_use_imm = 1'b1;
         end
         OP_LW: begin
            w_reg_we  = 1'b1;
            w_use_imm = 1'b1;
            w_is_load = 1'b1;
         end
         OP_SW: begin
            w_mem_we  = 1'b1;
            w_use_imm = 1'b1;
         end
         OP_BEQ: begin
            if (w_rd1 == w_rd2) begin
               pc_d = w_br_target;
            end
         end
         OP_J: begin
            pc_d = w_j_target;
         end
         OP_JAL: begin
            pc_d      = w_j_target;
            w_reg_we  = 1'b1;
            w_wa      = 5'd31;
            w_is_link = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_alu_b = w_use_imm ? w_sext : w_rd2;

   always_comb begin
      w_alu_y = w_rd1 + w_alu_b;
      case (w_alu_ctrl)
         ALU_ADD: w_alu_y = w_rd1 + w_alu_b;
         ALU_SUB: w_alu_y = w_rd1 - w_alu_b;
         ALU_AND: w_alu_y = w_rd1 & w_alu_b;
         ALU_OR:  w_alu_y = w_rd1 | w_alu_b;
         ALU_SLT: w_alu_y = ($signed(w_rd1) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
         default: w_alu_y = w_rd1 + w_alu_b;
      endcase
   end

   assign w_wb_data = w_is_link ? w_pc_plus4 :
                      w_is_load ? w_mem_rdata : w_alu_y;

   mips_regfile rf (
      .clk   (clk),
      .rst   (rst),
      .i_ra1 (w_rs),
      .i_ra2 (w_rt),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2),
      .i_we  (w_reg_we),
      .i_wa  (w_wa),
      .i_wd  (w_wb_data)
   );

   // Reset must not leak a store from whatever instruction PC points at.
   mips_dmem #(
      .DM_WORDS  (DM_WORDS),
      .DATA_BASE (DATA_BASE)
   ) dm (
      .clk     (clk),
      .i_addr  (w_alu_y),
      .i_we    (w_mem_we & ~rst),
      .i_wdata (w_rd2),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         PC <= TEXT_BASE;
      end else begin
         PC <= pc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_single_cycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_single_cycle
// Description : Self-checking bench for mips_single_cycle. Directed programs
//               with hand-derived results, then random programs compared
//               against an instruction-level reference interpreter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_single_cycle;

   localparam logic [31:0] TB_TEXT = 32'h0000_3000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [31:0] prog [$];

   // Reference interpreter state
   logic [31:0] m_rf [32];
   logic [31:0] m_dm [1024];
   logic [31:0] m_im [1024];
   logic [31:0] m_pc;

   mips_single_cycle dut (
      .clk (clk),
      .rst (rst)
   );

   always #5 clk = ~clk;

   // ---------------- assembler helpers ----------------
   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] jtype(input logic [5:0] op, input logic [31:0] addr);
      return {op, addr[27:2]};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 1024; i++) begin
         dut.im.instruction_memory[i] = 32'd0;
         m_im[i] = 32'd0;
      end
      for (int i = 0; i < prog.size(); i++) begin
         dut.im.instruction_memory[i] = prog[i];
         m_im[i] = prog[i];
      end
   endtask

   task automatic do_reset(input bit chk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_pc = TB_TEXT;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      if (chk) begin
         check("reset_pc", dut.PC, TB_TEXT);
         for (int i = 0; i < 32; i++) check($sformatf("reset_rf%0d", i), dut.rf.rf[i], 32'd0);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- reference interpreter ----------------
   task automatic m_write(input int r, input logic [31:0] v);
      if (r != 0) m_rf[r] = v;
   endtask

   task automatic model_step();
      logic [31:0] ins, a, b, s, nxt, addr, woff;
      int rs, rt, rd;
      woff = (m_pc - TB_TEXT) / 4;
      ins  = (woff < 1024) ? m_im[woff] : 32'd0;
      rs = int'(ins[25:21]);
      rt = int'(ins[20:16]);
      rd = int'(ins[15:11]);
      a = m_rf[rs];
      b = m_rf[rt];
      s = {{16{ins[15]}}, ins[15:0]};
      nxt = m_pc + 4;
      addr = a + s;
      case (ins[31:26])
         6'h00: case (ins[5:0])
                   6'h20: m_write(rd, a + b);
                   6'h22: m_write(rd, a - b);
                   6'h24: m_write(rd, a & b);
                   6'h25: m_write(rd, a | b);
                   6'h2A: m_write(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                   default: ;
                endcase
         6'h08: m_write(rt, a + s);
         6'h23: m_write(rt, (addr / 4 < 1024) ? m_dm[addr / 4] : 32'd0);
         6'h2B: if (addr / 4 < 1024) m_dm[addr / 4] = b;
         6'h04: if (a == b) nxt = m_pc + 4 + s * 4;
         6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
         6'h03: begin
                   m_write(31, m_pc + 4);
                   nxt = {nxt[31:28], ins[25:0], 2'b00};
                end
         default: ;
      endcase
      m_pc = nxt;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 1024; i++) m_dm[i] = 32'd0;

      // ===== ALU program =====
      prog.delete();
      prog.push_back(itype(6'h08, 0, 1, 5));
      prog.push_back(itype(6'h08, 0, 2, -3));
      prog.push_back(rtype(1, 2, 3, 6'h20));
      prog.push_back(rtype(1, 2, 4, 6'h22));
      prog.push_back(rtype(2, 1, 5, 6'h24));
      prog.push_back(rtype(2, 1, 6, 6'h25));
      prog.push_back(rtype(2, 1, 7, 6'h2A));
      prog.push_back(rtype(1, 1, 0, 6'h20));          // write to $0
      prog.push_back(itype(6'h3F, 0, 13, 16'h1234));  // unknown opcode
      prog.push_back(rtype(1, 1, 14, 6'h21));         // unknown funct
      prog.push_back(itype(6'h08, 0, 8, 16'h4000));
      for (int i = 0; i < 17; i++) prog.push_back(rtype(8, 8, 8, 6'h20));
      prog.push_back(itype(6'h08, 8, 9, -1));
      prog.push_back(itype(6'h08, 0, 10, 1));
      prog.push_back(rtype(9, 10, 11, 6'h20));
      prog.push_back(rtype(8, 9, 12, 6'h2A));
      load_prog();
      do_reset(1'b1);
      run(1);
      check("first_pc", dut.PC, 32'h0000_3004);
      check("first_r1", dut.rf.rf[1], 32'd5);
      check("first_r2_not_yet", dut.rf.rf[2], 32'd0);
      run(31);
      check("alu_pc", dut.PC, 32'h0000_3080);
      check("add_r3", dut.rf.rf[3], 32'd2);
      check("sub_r4", dut.rf.rf[4], 32'd8);
      check("and_r5", dut.rf.rf[5], 32'd5);
      check("or_r6", dut.rf.rf[6], 32'hFFFF_FFFD);
      check("slt_r7", dut.rf.rf[7], 32'd1);
      check("r0_zero", dut.rf.rf[0], 32'd0);
      check("unk_op_r13", dut.rf.rf[13], 32'd0);
      check("unk_fn_r14", dut.rf.rf[14], 32'd0);
      check("max_pos_r9", dut.rf.rf[9], 32'h7FFF_FFFF);
      check("wrap_r11", dut.rf.rf[11], 32'h8000_0000);
      check("slt_signed_r12", dut.rf.rf[12], 32'd1);

      // ===== memory program =====
      prog.delete();
      prog.push_back(itype(6'h08, 0, 1, 5));
      prog.push_back(itype(6'h08, 0, 3, 2));
      prog.push_back(itype(6'h08, 0, 5, 80));
      prog.push_back(itype(6'h2B, 5, 1, 0));
      prog.push_back(itype(6'h2B, 5, 3, 4));
      prog.push_back(itype(6'h23, 5, 6, 4));
      prog.push_back(itype(6'h23, 5, 7, 1));          // low bits ignored
      prog.push_back(itype(6'h2B, 5, 3, 10));         // byte 90 -> word 22
      load_prog();
      do_reset(1'b1);                                 // reset after ALU run clears regs
      run(8);
      check("dm20", dut.dm.dataMem[20], 32'd5);
      check("dm21", dut.dm.dataMem[21], 32'd2);
      check("dm22_unaligned", dut.dm.dataMem[22], 32'd2);
      check("lw_r6", dut.rf.rf[6], 32'd2);
      check("lw_unaligned_r7", dut.rf.rf[7], 32'd5);

      // ===== branch loop =====
      prog.delete();
      prog.push_back(itype(6'h08, 0, 1, 3));
      prog.push_back(itype(6'h08, 0, 2, 0));
      prog.push_back(itype(6'h04, 1, 0, 3));          // loop: beq $1,$0,exit
      prog.push_back(itype(6'h08, 1, 1, -1));
      prog.push_back(itype(6'h08, 2, 2, 1));
      prog.push_back(itype(6'h04, 0, 0, -4));         // back to loop
      prog.push_back(itype(6'h08, 0, 3, 9));          // exit
      load_prog();
      do_reset(1'b0);
      run(3);
      check("beq_not_taken_pc", dut.PC, 32'h0000_300C);
      run(3);
      check("beq_back_pc", dut.PC, 32'h0000_3008);
      run(10);
      check("loop_end_pc", dut.PC, 32'h0000_301C);
      check("loop_r1", dut.rf.rf[1], 32'd0);
      check("loop_iters_r2", dut.rf.rf[2], 32'd3);
      check("loop_exit_r3", dut.rf.rf[3], 32'd9);

      // ===== jumps =====
      prog.delete();
      prog.push_back(itype(6'h08, 0, 1, 1));          // 3000
      prog.push_back(jtype(6'h02, 32'h0000_300C));    // 3004
      prog.push_back(itype(6'h08, 0, 2, 99));         // 3008 skipped
      prog.push_back(itype(6'h08, 0, 3, 3));          // 300C
      prog.push_back(jtype(6'h03, 32'h0000_3020));    // 3010 jal
      prog.push_back(itype(6'h08, 0, 4, 4));          // 3014
      prog.push_back(jtype(6'h02, 32'h0000_3018));    // 3018 spin
      prog.push_back(itype(6'h08, 0, 2, 77));         // 301C skipped
      prog.push_back(itype(6'h08, 0, 5, 5));          // 3020
      prog.push_back(jtype(6'h02, 32'h0000_3014));    // 3024 return
      load_prog();
      do_reset(1'b0);
      run(2);
      check("j_pc", dut.PC, 32'h0000_300C);
      run(2);
      check("jal_pc", dut.PC, 32'h0000_3020);
      check("jal_r31", dut.rf.rf[31], 32'h0000_3014);
      run(2);
      check("ret_pc", dut.PC, 32'h0000_3014);
      run(2);
      check("spin_pc", dut.PC, 32'h0000_3018);
      check("no_delay_slot_r2", dut.rf.rf[2], 32'd0);
      check("jmp_r4", dut.rf.rf[4], 32'd4);
      check("jmp_r5", dut.rf.rf[5], 32'd5);

      // ===== random programs vs reference interpreter =====
      for (int t = 0; t < 3; t++) begin
         int body_start, plen;
         prog.delete();
         for (int k = 0; k < 8; k++) prog.push_back(itype(6'h2B, 0, 0, 80 + 4 * k));
         for (int k = 1; k <= 8; k++) prog.push_back(itype(6'h08, 0, k, int'($urandom_range(0, 65535))));
         body_start = prog.size();
         plen = body_start + 40;
         for (int idx = body_start; idx < plen; idx++) begin
            int kind, ra, rb, rc;
            logic [5:0] fns [5];
            fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
            kind = int'($urandom_range(0, 9));
            ra = int'($urandom_range(0, 8));
            rb = int'($urandom_range(0, 8));
            rc = int'($urandom_range(0, 8));
            case (kind)
               0, 1, 2, 3: prog.push_back(rtype(ra, rb, rc, fns[$urandom_range(0, 4)]));
               4: prog.push_back(itype(6'h08, ra, rb, int'($urandom_range(0, 65535))));
               5: prog.push_back(itype(6'h23, 0, rb, 80 + 4 * int'($urandom_range(0, 7)) + int'($urandom_range(0, 3))));
               6: prog.push_back(itype(6'h2B, 0, rb, 80 + 4 * int'($urandom_range(0, 7)) + int'($urandom_range(0, 3))));
               7: prog.push_back(itype(6'h04, ra, ($urandom_range(0, 1) == 1) ? ra : rb, int'($urandom_range(0, 2))));
               8: prog.push_back(jtype(6'h03, TB_TEXT + 32'(4 * (idx + 1 + int'($urandom_range(0, 2))))));
               default: prog.push_back(($urandom_range(0, 1) == 1) ? itype(6'h3F, ra, rb, 16'h5A5A)
                                                                    : rtype(ra, rb, rc, 6'h21));
            endcase
         end
         load_prog();
         do_reset(1'b0);
         for (int c = 0; c < plen + 4; c++) begin
            model_step();
            run(1);
            check($sformatf("rnd%0d_pc_c%0d", t, c), dut.PC, m_pc);
         end
         for (int r = 0; r < 32; r++) check($sformatf("rnd%0d_rf%0d", t, r), dut.rf.rf[r], m_rf[r]);
         for (int w = 20; w < 28; w++) check($sformatf("rnd%0d_dm%0d", t, w), dut.dm.dataMem[w], m_dm[w]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
